// File: rtl/hms_display_scan.sv
// Multiplexed 8-digit 7-segment scanner for an HH:MM:SS time-of-day value.
// One digit is lit per scan slot. The time is snapshotted once per frame, so a
// displayed frame never mixes two different seconds. Out-of-range fields are
// shown as dashes. Digits 6 and 7 are blank slots that keep the duty cycle equal.
module hms_display_scan #(
    parameter int SCAN_DIV    = 100000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       dp_en,
    output logic [7:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int             PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [7:0]     AN_OFF     = {8{AN_ACT_LOW}};
    localparam logic [6:0]     SEG_OFF    = {7{SEG_ACT_LOW}};
    localparam logic [6:0]     GLYPH_DASH = 7'h40;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [4:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic          r_dp_en;
    logic          r_upd;

    logic          w_tick;
    logic [3:0]    w_sec_tens, w_sec_ones;
    logic [3:0]    w_min_tens, w_min_ones;
    logic [3:0]    w_hour_tens, w_hour_ones;
    logic          w_sec_bad, w_min_bad, w_hour_bad;
    logic [3:0]    w_val;
    logic          w_bad;
    logic          w_blank;
    logic [6:0]    w_seg_hi;
    logic          w_dp_hi;
    logic [7:0]    w_an_hi;

    // Tens digit by threshold compare; valid for inputs 0..59 only.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if      (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v, input logic [3:0] t);
        logic [5:0] r;
        r = v - ({2'b00, t} * 6'd10);
        return r[3:0];
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a} for decimal digits.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    assign w_tick      = (r_presc == PRESC_MAX);

    assign w_sec_tens  = tens_of(r_sec);
    assign w_sec_ones  = ones_of(r_sec, w_sec_tens);
    assign w_min_tens  = tens_of(r_min);
    assign w_min_ones  = ones_of(r_min, w_min_tens);
    assign w_hour_tens = tens_of({1'b0, r_hour});
    assign w_hour_ones = ones_of({1'b0, r_hour}, w_hour_tens);

    assign w_sec_bad   = (r_sec  > 6'd59);
    assign w_min_bad   = (r_min  > 6'd59);
    assign w_hour_bad  = (r_hour > 5'd23);

    assign w_an_hi     = 8'd1 << r_idx;

    // Prescaler: one tick per scan slot.
    always_ff @(posedge clk) begin
        if (!reset_n)     r_presc <= '0;
        else if (w_tick)  r_presc <= '0;
        else              r_presc <= r_presc + 1'b1;
    end

    // Stage 1: advance the digit index and snapshot the time at frame start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx        <= 3'd7;
            r_hour       <= '0;
            r_min        <= '0;
            r_sec        <= '0;
            r_dp_en      <= 1'b0;
            r_upd        <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            r_upd      <= w_tick;
            frame_tick <= w_tick && (r_idx == 3'd7);
            if (w_tick) begin
                r_idx <= r_idx + 3'd1;
                if (r_idx == 3'd7) begin
                    r_hour  <= hour;
                    r_min   <= minute;
                    r_sec   <= second;
                    r_dp_en <= dp_en;
                end
            end
        end
    end

    // Select the digit value and its range flag for the current slot.
    always_comb begin
        w_val   = 4'd0;
        w_bad   = 1'b0;
        w_blank = 1'b0;
        case (r_idx)
            3'd0:    begin w_val = w_sec_ones;  w_bad = w_sec_bad;  end
            3'd1:    begin w_val = w_sec_tens;  w_bad = w_sec_bad;  end
            3'd2:    begin w_val = w_min_ones;  w_bad = w_min_bad;  end
            3'd3:    begin w_val = w_min_tens;  w_bad = w_min_bad;  end
            3'd4:    begin w_val = w_hour_ones; w_bad = w_hour_bad; end
            3'd5:    begin w_val = w_hour_tens; w_bad = w_hour_bad; end
            default: w_blank = 1'b1;
        endcase
    end

    // Segment and separator pattern, still active-high.
    always_comb begin
        w_seg_hi = 7'h00;
        w_dp_hi  = 1'b0;
        if (!w_blank) begin
            w_seg_hi = w_bad ? GLYPH_DASH : glyph(w_val);
            w_dp_hi  = r_dp_en && ((r_idx == 3'd2) || (r_idx == 3'd4));
        end
    end

    // Stage 2: register the display outputs one cycle after the tick; polarity applied here only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            anode <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= SEG_ACT_LOW;
        end else if (r_upd) begin
            anode <= AN_ACT_LOW  ? ~w_an_hi  : w_an_hi;
            seg   <= SEG_ACT_LOW ? ~w_seg_hi : w_seg_hi;
            dp    <= SEG_ACT_LOW ? ~w_dp_hi  : w_dp_hi;
        end
    end

endmodule

// File: tb/tb_hms_display_scan.sv
// Scoreboard bench for hms_display_scan with SCAN_DIV=4 and active-low outputs.
// The stimulus pushes the eight expected slots of each frame as it sets up the
// time; a monitor pops one entry whenever a new digit is lit.
module tb_hms_display_scan;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam int NF = 24;
    localparam int RF = 9;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       dp_en;
    logic [7:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    bit         done   = 1'b0;
    logic [7:0] prev_an = 8'hFF;

    logic [6:0] digit_glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                     7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int fh [NF];
    int fm [NF];
    int fs [NF];
    bit fd [NF];

    hms_display_scan #(
        .SCAN_DIV    (4),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .dp_en      (dp_en),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Expected output of slot i for a frame showing h:m:s, written from the display rules.
    function automatic exp_t model(input int h, input int m, input int s, input bit d, input int i);
        exp_t e;
        int   digits [6];
        bit   bad;
        logic [6:0] seg_on;
        logic       dp_on;
        digits[0] = s % 10; digits[1] = s / 10;
        digits[2] = m % 10; digits[3] = m / 10;
        digits[4] = h % 10; digits[5] = h / 10;
        bad = (i < 2) ? (s > 59) : (i < 4) ? (m > 59) : (h > 23);
        if (i >= 6) begin
            seg_on = 7'h00;
            dp_on  = 1'b0;
        end else begin
            seg_on = bad ? 7'h40 : digit_glyph[digits[i]];
            dp_on  = d && (i == 2 || i == 4);
        end
        e.an  = ~(8'h01 << i);
        e.seg = ~seg_on;
        e.dp  = ~dp_on;
        return e;
    endfunction

    task automatic set_frame(input int f);
        hour   = fh[f][4:0];
        minute = fm[f][5:0];
        second = fs[f][5:0];
        dp_en  = fd[f];
        for (int i = 0; i < 8; i++) q.push_back(model(fh[f], fm[f], fs[f], fd[f], i));
    endtask

    task automatic set_garbage();
        hour   = 5'($urandom);
        minute = 6'($urandom);
        second = 6'($urandom);
        dp_en  = 1'($urandom);
    endtask

    // Monitor: each newly lit digit is one scoreboard transaction.
    always begin
        @(posedge clk);
        #1;
        if (!done) begin
            if (anode != prev_an && anode != 8'hFF) begin
                if (q.size() == 0) begin
                    chk("unexpected_slot", {16'h0, anode, seg, dp}, 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("slot", {16'h0, anode, seg, dp}, {16'h0, e.an, e.seg, e.dp});
                end
            end
            prev_an = anode;
        end
    end

    initial begin
        fh[0] = 12; fm[0] = 34; fs[0] = 56; fd[0] = 1;
        fh[1] = 12; fm[1] = 34; fs[1] = 57; fd[1] = 1;
        fh[2] = 12; fm[2] = 34; fs[2] = 60; fd[2] = 0;
        fh[3] = 12; fm[3] = 60; fs[3] = 5;  fd[3] = 1;
        fh[4] = 24; fm[4] = 0;  fs[4] = 0;  fd[4] = 1;
        fh[5] = 23; fm[5] = 59; fs[5] = 59; fd[5] = 1;
        fh[6] = 0;  fm[6] = 0;  fs[6] = 0;  fd[6] = 0;
        fh[7] = 31; fm[7] = 63; fs[7] = 63; fd[7] = 1;
        fh[8] = 1;  fm[8] = 5;  fs[8] = 9;  fd[8] = 1;
        for (int f = 9; f < NF; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                fh[f] = $urandom_range(0, 31);
                fm[f] = $urandom_range(0, 63);
                fs[f] = $urandom_range(0, 63);
            end else begin
                fh[f] = $urandom_range(0, 23);
                fm[f] = $urandom_range(0, 59);
                fs[f] = $urandom_range(0, 59);
            end
            fd[f] = 1'($urandom_range(0, 1));
        end

        reset_n = 1'b0;
        set_garbage();
        repeat (3) @(negedge clk);
        chk("reset_anode", {24'h0, anode}, 32'hFF);
        chk("reset_seg",   {25'h0, seg},   32'h7F);
        chk("reset_dp",    {31'h0, dp},    32'h1);
        chk("reset_tick",  {31'h0, frame_tick}, 32'h0);

        set_frame(0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("tick_early", {31'h0, frame_tick}, 32'h0);
        @(negedge clk);

        for (int f = 0; f < NF; f++) begin
            chk("frame_tick_hi", {31'h0, frame_tick}, 32'h1);
            set_garbage();
            if (f == RF) begin
                repeat (18) @(negedge clk);
                q.delete();
                set_frame(f + 1);
                reset_n = 1'b0;
                @(negedge clk);
                chk("midreset_anode", {24'h0, anode}, 32'hFF);
                chk("midreset_seg",   {25'h0, seg},   32'h7F);
                chk("midreset_dp",    {31'h0, dp},    32'h1);
                chk("midreset_tick",  {31'h0, frame_tick}, 32'h0);
                reset_n = 1'b1;
                repeat (4) @(negedge clk);
            end else if (f < NF - 1) begin
                repeat (16) @(negedge clk);
                chk("frame_tick_lo", {31'h0, frame_tick}, 32'h0);
                set_frame(f + 1);
                repeat (16) @(negedge clk);
            end else begin
                repeat (30) @(negedge clk);
            end
        end

        done = 1'b1;
        chk("queue_drained", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
